// File: rtl/shift_pkg.sv
// Shared shift-type codes and sequencer state encoding for the MCU, ALU_32 and seq_shifter32.
package shift_pkg;

  localparam int unsigned TYPE_W = 5;

  localparam logic [TYPE_W-1:0] SH_SLL = 5'h0C;
  localparam logic [TYPE_W-1:0] SH_SRL = 5'h0D;
  localparam logic [TYPE_W-1:0] SH_SRA = 5'h0E;
  localparam logic [TYPE_W-1:0] SH_ROL = 5'h1A;
  localparam logic [TYPE_W-1:0] SH_ROR = 5'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step1.sv
// Combinational one-bit shift step; carry is the bit pushed out, zero for rotates and unknown types.
module shift_step1
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]  w,
  input  logic [TYPE_W-1:0] shift_type,
  output logic [WIDTH-1:0]  w_nxt_c,
  output logic              c_nxt_c
);

  always_comb begin
    w_nxt_c = w;
    c_nxt_c = 1'b0;
    case (shift_type)
      SH_SLL: begin
        w_nxt_c = {w[WIDTH-2:0], 1'b0};
        c_nxt_c = w[WIDTH-1];
      end
      SH_SRL: begin
        w_nxt_c = {1'b0, w[WIDTH-1:1]};
        c_nxt_c = w[0];
      end
      SH_SRA: begin
        w_nxt_c = {w[WIDTH-1], w[WIDTH-1:1]};
        c_nxt_c = w[0];
      end
      SH_ROL: w_nxt_c = {w[WIDTH-2:0], w[WIDTH-1]};
      SH_ROR: w_nxt_c = {w[0], w[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle shifter: one step per cycle through shift_step1, start/busy/done handshake,
// results held in output registers until the next completion.
module seq_shifter32
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [TYPE_W-1:0]          shift_type,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  input  logic [WIDTH-1:0]           T,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           Y,
  output logic                       C
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_t              state;
  logic [SW-1:0]       cnt;
  logic [WIDTH-1:0]    w;
  logic                carry;
  logic [TYPE_W-1:0]   type_q;
  logic [WIDTH-1:0]    w_nxt_c;
  logic                c_nxt_c;

  shift_step1 #(.WIDTH(WIDTH)) u_step (
    .w          (w),
    .shift_type (type_q),
    .w_nxt_c    (w_nxt_c),
    .c_nxt_c    (c_nxt_c)
  );

  // Y/C/done are loaded on the edge entering DONE so they are valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      w      <= '0;
      carry  <= 1'b0;
      type_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Y      <= '0;
      C      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w      <= T;
            type_q <= shift_type;
            cnt    <= shamt;
            carry  <= 1'b0;
            busy   <= 1'b1;
            if (shamt == '0) begin
              state <= DONE;
              done  <= 1'b1;
              Y     <= T;
              C     <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w     <= w_nxt_c;
          carry <= c_nxt_c;
          cnt   <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            Y     <= w_nxt_c;
            C     <= c_nxt_c;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter32.sv
// Self-checking bench for seq_shifter32: directed table, handshake corner sequences, random vs reference model.
module tb_seq_shifter32;
  import shift_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  shift_type;
  logic [4:0]  shamt;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic [31:0] Y;
  logic        C;

  int ntests = 0;
  int nfail  = 0;

  seq_shifter32 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .shift_type (shift_type),
    .shamt      (shamt),
    .T          (T),
    .busy       (busy),
    .done       (done),
    .Y          (Y),
    .C          (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ty;
    logic [31:0] t;
    int          s;
    logic [31:0] ey;
    logic        ec;
    string       nm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, carry = last bit to leave the word.
  function automatic logic [32:0] ref_model(input logic [4:0] ty, input logic [31:0] t, input int s);
    logic [31:0] y;
    logic        c;
    y = t;
    c = 1'b0;
    if (s != 0) begin
      case (ty)
        SH_SLL: begin y = t << s; c = t[32-s]; end
        SH_SRL: begin y = t >> s; c = t[s-1]; end
        SH_SRA: begin y = 32'($signed(t) >>> s); c = t[s-1]; end
        SH_ROL: y = (t << s) | (t >> (32 - s));
        SH_ROR: y = (t >> s) | (t << (32 - s));
        default: ;
      endcase
    end
    return {c, y};
  endfunction

  // Issue one request from idle, scramble inputs after acceptance, check latency and result.
  task automatic run_req(input logic [4:0] ty, input logic [31:0] t, input int s,
                         input logic [31:0] ey, input logic ec, input string nm);
    int cyc;
    bit busy_ok;
    shift_type = ty;
    T          = t;
    shamt      = 5'(s);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    T          = $urandom;
    shift_type = 5'($urandom);
    shamt      = 5'($urandom);
    cyc        = 1;
    busy_ok    = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    check({nm, " done"}, 64'(done), 64'(1));
    check({nm, " latency"}, 64'(cyc), 64'(s + 1));
    check({nm, " busy in flight"}, 64'({busy_ok, busy}), 64'(2'b11));
    check({nm, " Y"}, 64'(Y), 64'(ey));
    check({nm, " C"}, 64'(C), 64'(ec));
    tick();
    check({nm, " idle after"}, 64'({busy, done}), 64'(0));
    check({nm, " Y held"}, 64'({C, Y}), 64'({ec, ey}));
  endtask

  vec_t vecs[$];
  logic [4:0] codes[5] = '{SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR};

  initial begin
    int dcount;
    logic [32:0] r;
    logic [4:0]  ty;
    logic [31:0] t;
    int          s;

    reset = 1'b1; start = 1'b0; shift_type = '0; shamt = '0; T = '0;
    repeat (3) tick();
    check("reset outputs", 64'({busy, done, C, Y}), 64'(0));
    reset = 1'b0;
    tick();

    vecs.push_back('{SH_SLL, 32'h8000_0001, 1,  32'h0000_0002, 1'b1, "sll1"});
    vecs.push_back('{SH_SRA, 32'h8000_0000, 4,  32'hF800_0000, 1'b0, "sra4"});
    vecs.push_back('{SH_SRL, 32'h0000_000F, 4,  32'h0000_0000, 1'b1, "srl4"});
    vecs.push_back('{SH_ROR, 32'h0000_0001, 31, 32'h0000_0002, 1'b0, "ror31"});
    vecs.push_back('{SH_ROL, 32'h8000_0001, 1,  32'h0000_0003, 1'b0, "rol1"});
    vecs.push_back('{SH_SRL, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 1'b0, "srl0"});
    vecs.push_back('{5'h00,  32'h1234_5678, 3,  32'h1234_5678, 1'b0, "unk3"});
    vecs.push_back('{SH_SLL, 32'hFFFF_FFFF, 31, 32'h8000_0000, 1'b1, "sll31"});
    vecs.push_back('{SH_SRA, 32'h8000_0001, 31, 32'hFFFF_FFFF, 1'b0, "sra31"});
    foreach (vecs[i])
      run_req(vecs[i].ty, vecs[i].t, vecs[i].s, vecs[i].ey, vecs[i].ec, vecs[i].nm);

    // start held high through busy: cycle-1 request ignored, cycle-2 request accepted.
    dcount = 0;
    shift_type = SH_SRL; T = 32'hDEAD_BEEF; shamt = 5'd0; start = 1'b1;
    tick();
    if (done) dcount++;
    check("hold c1 Y", 64'({busy, done, Y}), 64'({2'b11, 32'hDEAD_BEEF}));
    shift_type = SH_SLL; T = 32'h1; shamt = 5'd2;
    tick();
    if (done) dcount++;
    check("hold c2 idle", 64'({busy, done, Y}), 64'({2'b00, 32'hDEAD_BEEF}));
    tick();
    if (done) dcount++;
    start = 1'b0;
    check("hold c3 busy", 64'(busy), 64'(1));
    for (int c = 4; c <= 10; c++) begin
      tick();
      if (done) dcount++;
      if (c == 5) check("hold c5 result", 64'({done, C, Y}), 64'({2'b10, 32'h4}));
    end
    check("hold done pulses", 64'(dcount), 64'(2));

    // Reset mid-shift discards the request.
    shift_type = SH_SLL; T = 32'hA5A5_0F0F; shamt = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset outputs", 64'({busy, done, C, Y}), 64'(0));
    dcount = 0;
    repeat (25) begin
      tick();
      if (done || busy) dcount++;
    end
    check("midreset quiet", 64'(dcount), 64'(0));
    run_req(SH_SRL, 32'h8000_0000, 5, 32'h0400_0000, 1'b0, "post reset");

    // Reset and start together: start dropped.
    reset = 1'b1; start = 1'b1; shift_type = SH_SLL; T = 32'h1; shamt = 5'd0;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("reset+start dropped", 64'({busy, done, C, Y}), 64'(0));

    for (int k = 0; k < 60; k++) begin
      ty = ($urandom_range(0, 5) == 5) ? 5'($urandom) : codes[$urandom_range(0, 4)];
      t  = $urandom;
      s  = (k < 4) ? k * 31 % 32 : int'($urandom_range(0, 31));
      r  = ref_model(ty, t, s);
      run_req(ty, t, s, r[31:0], r[32], $sformatf("rnd%0d ty%h s%0d", k, ty, s));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/seq_shifter32.md
# seq_shifter32

Multi-cycle, one-bit-per-cycle shift unit serving the ALU_32 for register-variable shifts (SLLV/SRLV/SRAV and rotates). It accepts an operand, shift amount and the MCU shift type through a start/busy/done handshake. It produces the same result and carry semantics as the single-cycle barrel shifter, using one step-shifter instead of a 32-way mux. Results are held stable until the next accepted request.

## Interface
- WIDTH, 32, operand width; shamt width is SW = clog2(WIDTH) (5 at default).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy = 0.
- type  in  5  shift select: 5'h0C SLL, 5'h0D SRL, 5'h0E SRA, 5'h1A ROL, 5'h1B ROR.
- shamt  in  SW  shift amount (register-sourced, low SW bits).
- T  in  WIDTH  operand.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse; Y/C valid in this cycle and held afterwards.
- Y  out  WIDTH  shifted result.
- C  out  1  carry: last bit shifted out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start = 1:
  - latch T into the work register, type into the type register, shamt into the counter cnt; clear the carry register.
  - next state is SHIFT if shamt != 0, else DONE.
- SHIFT: each cycle applies one step and decrements cnt.
  - SLL: C <= w[W-1]; w <= {w[W-2:0], 0}.
  - SRL: C <= w[0]; w <= {0, w[W-1:1]}.
  - SRA: C <= w[0]; w <= {w[W-1], w[W-1:1]}.
  - ROL: w <= {w[W-2:0], w[W-1]}; C stays 0.
  - ROR: w <= {w[0], w[W-1:1]}; C stays 0.
  - Any other type: w and C unchanged.
  - When cnt == 1 the step is applied and next state is DONE.
- DONE: done = 1 for one cycle, Y/C registers loaded from w/carry, next state IDLE.
- Y and C change only in the DONE cycle and hold until the next DONE.
- shamt = 0: Y = T, C = 0 for every type.
- Unknown type: Y = T, C = 0 after shamt steps; no error flag.
- start while busy (SHIFT or DONE): ignored and not queued.
- Inputs T, type and shamt are sampled only at acceptance; later changes have no effect.
- Reset (any state, including mid-shift): state = IDLE, cnt = 0, work register = 0; outputs Y = 0, C = 0, done = 0, busy = 0. A request in flight is discarded.

## Timing
- Acceptance in cycle 0: busy = 1 from cycle 1 through cycle shamt+1.
- done = 1 in cycle shamt+1 only; for shamt = 0, done in cycle 1.
- Worst case (shamt = 31): done in cycle 32.
- busy = 0 in cycle shamt+2, when a new start is accepted. Minimum issue interval is shamt+2 cycles.
- No combinational path from any input to any output.
- start and reset in the same cycle: reset wins, start is dropped.

## Structure
- Shared package shift_pkg:
  - type code constants SH_SLL = 5'h0C, SH_SRL = 5'h0D, SH_SRA = 5'h0E, SH_ROL = 5'h1A, SH_ROR = 5'h1B, so the MCU, ALU_32 and this block agree.
  - state encoding IDLE/SHIFT/DONE.
- One sub-module, shift_step1: combinational one-bit step, (w, type) -> (w_next, c_next).
- Top level holds the FSM, cnt, work/carry registers and output registers.

## Test plan
- SLL, T = 32'h8000_0001, shamt = 1 -> done in cycle 2, Y = 32'h0000_0002, C = 1.
- SRA, T = 32'h8000_0000, shamt = 4 -> done in cycle 5, Y = 32'hF800_0000, C = 0. SRL, T = 32'h0000_000F, shamt = 4 -> Y = 0, C = 1.
- ROR, T = 32'h0000_0001, shamt = 31 -> busy cycles 1-32, done in cycle 32, Y = 32'h0000_0002, C = 0. ROL, T = 32'h8000_0001, shamt = 1 -> Y = 32'h0000_0003, C = 0.
- shamt = 0, SRL, T = 32'hDEAD_BEEF -> done in cycle 1, Y = 32'hDEAD_BEEF, C = 0. Then start with T = 1 pulsed every cycle during busy -> exactly one more result, accepted in cycle 2.
- SLL shamt = 20 started, reset asserted in cycle 10 -> next cycle Y = 0, C = 0, busy = 0, done stays 0. A fresh request then completes correctly.
- Type 5'h00, T = 32'h1234_5678, shamt = 3 -> done in cycle 4, Y = 32'h1234_5678, C = 0. Operand changes after acceptance -> no effect on Y.
